// File: rtl/apbspi_pkg.sv
// Shared types and constants for the apbspi SPI slave.
// Holds the slave FSM encoding and the default SPI word width.
package apbspi_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    localparam int SPI_WORD_W = 32;

endpackage

// File: rtl/apbspi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous SPI control line.
// Adds rise/fall detection against one extra delay flop.
module apbspi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   dly_r;
    logic                   q_s;

    // Synchroniser chain plus the edge-reference delay flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{RST_VAL}};
            dly_r  <= RST_VAL;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], d};
            dly_r  <= sync_r[SYNC_STAGES-1];
        end
    end

    assign q_s  = sync_r[SYNC_STAGES-1];
    assign rise = q_s & ~dly_r;
    assign fall = ~q_s & dly_r;

endmodule

// File: rtl/apbspi_spi_slave.sv
// Mode-0 SPI slave oversampled in the pclk domain, MSB-first words.
// TX words come from an inline FIFO; RX words go out on a valid/ready port.
module apbspi_spi_slave
    import apbspi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_WORD_W,
    parameter int TX_DEPTH    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  en,
    input  logic                  sclk_i,
    input  logic                  cs_n_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overrun,
    output logic                  tx_underrun,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int AW = $clog2(TX_DEPTH);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    spi_state_e              state_r, state_next_s;
    logic [CW-1:0]           cnt_r, cnt_next_s;
    logic                    word_seen_r, word_seen_next_s;
    logic [DATA_WIDTH-1:0]   tx_shift_r, tx_shift_next_s, tx_step_s, load_word_s;
    logic [DATA_WIDTH-1:0]   rx_shift_r, rx_shift_next_s, rx_word_s;
    logic                    load_s, complete_s, frame_err_s;
    logic                    sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;
    logic [SYNC_STAGES-1:0]  mosi_sync_r;
    logic                    mosi_s;

    logic [AW:0]             wr_ptr_r, rd_ptr_r;
    logic [DATA_WIDTH-1:0]   fifo_mem_r [TX_DEPTH];
    logic                    fifo_empty_s, fifo_full_s, push_s, pop_s;

    logic                    miso_r, miso_oe_r;
    logic [DATA_WIDTH-1:0]   rx_data_r;
    logic                    rx_valid_r, rx_overrun_r, tx_underrun_r, frame_err_r;

    apbspi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk   (pclk),
        .rst_n (presetn),
        .d     (sclk_i),
        .rise  (sclk_rise_s),
        .fall  (sclk_fall_s)
    );

    apbspi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk   (pclk),
        .rst_n (presetn),
        .d     (cs_n_i),
        .rise  (cs_rise_s),
        .fall  (cs_fall_s)
    );

    // mosi needs no edge detect, only the same synchroniser depth as sclk
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi_i};
        end
    end

    assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                          (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign push_s       = tx_valid & ~fifo_full_s;
    assign pop_s        = load_s & ~fifo_empty_s;
    assign load_word_s  = fifo_empty_s ? {DATA_WIDTH{1'b0}} : fifo_mem_r[rd_ptr_r[AW-1:0]];
    assign rx_word_s    = {rx_shift_r[DATA_WIDTH-2:0], mosi_s};

    // FSM state register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and shift/count datapath decode
    always_comb begin
        state_next_s     = state_r;
        cnt_next_s       = cnt_r;
        word_seen_next_s = word_seen_r;
        rx_shift_next_s  = rx_shift_r;
        tx_step_s        = tx_shift_r;
        load_s           = 1'b0;
        complete_s       = 1'b0;
        frame_err_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (en && cs_fall_s) begin
                    state_next_s     = ST_ACTIVE;
                    load_s           = 1'b1;
                    cnt_next_s       = '0;
                    word_seen_next_s = 1'b0;
                    rx_shift_next_s  = '0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (!en || cs_rise_s) begin
                    state_next_s = ST_IDLE;
                    frame_err_s  = (cnt_r != '0);
                    cnt_next_s   = '0;
                end else if (sclk_rise_s) begin
                    rx_shift_next_s = rx_word_s;
                    if (cnt_r == LAST_BIT) begin
                        cnt_next_s       = '0;
                        complete_s       = 1'b1;
                        word_seen_next_s = 1'b1;
                    end else begin
                        cnt_next_s = cnt_r + CW'(1);
                    end
                end else if (sclk_fall_s) begin
                    // Counter 0 on a fall means a word just finished: stream the next one
                    if (cnt_r != '0) begin
                        tx_step_s = {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
                    end else if (word_seen_r) begin
                        load_s = 1'b1;
                    end else begin
                        load_s = 1'b0;
                    end
                end else begin
                    state_next_s = ST_ACTIVE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        tx_shift_next_s = load_s ? load_word_s : tx_step_s;
    end

    // Shift registers, bit counter and registered pin/pulse outputs
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_r         <= '0;
            word_seen_r   <= 1'b0;
            tx_shift_r    <= '0;
            rx_shift_r    <= '0;
            miso_r        <= 1'b0;
            miso_oe_r     <= 1'b0;
            tx_underrun_r <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            cnt_r         <= cnt_next_s;
            word_seen_r   <= word_seen_next_s;
            tx_shift_r    <= tx_shift_next_s;
            rx_shift_r    <= rx_shift_next_s;
            miso_r        <= (state_next_s == ST_ACTIVE) ? tx_shift_next_s[DATA_WIDTH-1] : 1'b0;
            miso_oe_r     <= (state_next_s == ST_ACTIVE);
            tx_underrun_r <= load_s & fifo_empty_s;
            frame_err_r   <= frame_err_s;
        end
    end

    // RX hold register: a completed word is dropped only if the old one is still pending
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rx_data_r    <= '0;
            rx_valid_r   <= 1'b0;
            rx_overrun_r <= 1'b0;
        end else begin
            rx_overrun_r <= 1'b0;
            if (complete_s) begin
                if (!rx_valid_r || rx_ready) begin
                    rx_data_r  <= rx_word_s;
                    rx_valid_r <= 1'b1;
                end else begin
                    rx_overrun_r <= 1'b1;
                end
            end else if (rx_valid_r && rx_ready) begin
                rx_valid_r <= 1'b0;
            end else begin
                rx_valid_r <= rx_valid_r;
            end
        end
    end

    // TX FIFO pointers, with one extra wrap bit to separate full from empty
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // TX FIFO storage
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < TX_DEPTH; i++) begin
                fifo_mem_r[i] <= '0;
            end
        end else if (push_s) begin
            fifo_mem_r[wr_ptr_r[AW-1:0]] <= tx_data;
        end
    end

    assign miso_o      = miso_r;
    assign miso_oe_o   = miso_oe_r;
    assign tx_ready    = ~fifo_full_s;
    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;
    assign rx_overrun  = rx_overrun_r;
    assign tx_underrun = tx_underrun_r;
    assign frame_err   = frame_err_r;
    assign busy        = (state_r == ST_ACTIVE);

endmodule

// File: tb/tb_apbspi_spi_slave.sv
// Directed self-checking bench for apbspi_spi_slave acting as a mode-0 SPI master.
// Each task drives one scenario and compares against hand-computed words.
module tb_apbspi_spi_slave;

    localparam int H = 6;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        en = 1'b0;
    logic        sclk_i = 1'b0;
    logic        cs_n_i = 1'b1;
    logic        mosi_i = 1'b0;
    logic [31:0] tx_data = 32'h0;
    logic        tx_valid = 1'b0;
    logic        rx_ready = 1'b0;
    logic        miso_o, miso_oe_o, tx_ready, rx_valid;
    logic        rx_overrun, tx_underrun, frame_err, busy;
    logic [31:0] rx_data;

    int          checks = 0;
    int          failures = 0;
    int          und_cnt = 0;
    int          ovr_cnt = 0;
    int          fe_cnt = 0;
    logic [31:0] rx_q [$];

    apbspi_spi_slave dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .en          (en),
        .sclk_i      (sclk_i),
        .cs_n_i      (cs_n_i),
        .mosi_i      (mosi_i),
        .miso_o      (miso_o),
        .miso_oe_o   (miso_oe_o),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_overrun  (rx_overrun),
        .tx_underrun (tx_underrun),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 pclk = ~pclk;

    // Record accepted RX words and count pulse outputs
    always @(negedge pclk) begin
        if (presetn) begin
            if (rx_valid && rx_ready) rx_q.push_back(rx_data);
            if (tx_underrun) und_cnt++;
            if (rx_overrun) ovr_cnt++;
            if (frame_err) fe_cnt++;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic push(input logic [31:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        wait_cyc(1);
        tx_valid = 1'b0;
    endtask

    task automatic frame_begin();
        cs_n_i = 1'b0;
        wait_cyc(H);
    endtask

    task automatic frame_end();
        if (sclk_i) begin
            sclk_i = 1'b0;
            wait_cyc(H);
        end
        cs_n_i = 1'b1;
        wait_cyc(2 * H);
    endtask

    // Master side of nbits: fall, drive mosi, sample miso, rise; leaves sclk high
    task automatic spi_word(input logic [31:0] mo, input int nbits, output logic [31:0] mi);
        mi = 32'h0;
        for (int i = 0; i < nbits; i++) begin
            if (sclk_i) sclk_i = 1'b0;
            mosi_i = mo[31-i];
            wait_cyc(H);
            mi = {mi[30:0], miso_o};
            sclk_i = 1'b1;
            wait_cyc(H);
        end
    endtask

    task automatic test_reset();
        wait_cyc(3);
        checks++; if (miso_o !== 1'b0) begin failures++; $display("FAIL reset_miso got %b exp 0", miso_o); end
        checks++; if (miso_oe_o !== 1'b0) begin failures++; $display("FAIL reset_oe got %b exp 0", miso_oe_o); end
        checks++; if (rx_data !== 32'h0) begin failures++; $display("FAIL reset_rx_data got %h exp 0", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
        checks++; if ({rx_overrun, tx_underrun, frame_err} !== 3'b000) begin failures++; $display("FAIL reset_pulses got %b exp 000", {rx_overrun, tx_underrun, frame_err}); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got %b exp 1", tx_ready); end
        presetn = 1'b1;
        en = 1'b1;
        wait_cyc(2);
    endtask

    task automatic test_stream(input string tag);
        logic [31:0] m0, m1;
        push(32'hA5A50F0F);
        push(32'h12345678);
        rx_q.delete();
        rx_ready = 1'b1;
        frame_begin();
        spi_word(32'hDEADBEEF, 32, m0);
        checks++; if ({busy, miso_oe_o} !== 2'b11) begin failures++; $display("FAIL %s_active got %b exp 11", tag, {busy, miso_oe_o}); end
        spi_word(32'hCAFEF00D, 32, m1);
        frame_end();
        checks++; if (m0 !== 32'hA5A50F0F) begin failures++; $display("FAIL %s_miso0 got %h exp a5a50f0f", tag, m0); end
        checks++; if (m1 !== 32'h12345678) begin failures++; $display("FAIL %s_miso1 got %h exp 12345678", tag, m1); end
        checks++; if ({busy, miso_oe_o} !== 2'b00) begin failures++; $display("FAIL %s_idle got %b exp 00", tag, {busy, miso_oe_o}); end
        checks++;
        if (rx_q.size() !== 2) begin
            failures++; $display("FAIL %s_rx_count got %0d exp 2", tag, rx_q.size());
        end else begin
            checks++; if (rx_q[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL %s_rx0 got %h exp deadbeef", tag, rx_q[0]); end
            checks++; if (rx_q[1] !== 32'hCAFEF00D) begin failures++; $display("FAIL %s_rx1 got %h exp cafef00d", tag, rx_q[1]); end
        end
    endtask

    task automatic test_underrun();
        logic [31:0] m;
        rx_q.delete();
        und_cnt = 0;
        frame_begin();
        spi_word(32'h00000001, 32, m);
        checks++; if (und_cnt !== 1) begin failures++; $display("FAIL underrun_count got %0d exp 1", und_cnt); end
        checks++; if (m !== 32'h0) begin failures++; $display("FAIL underrun_miso got %h exp 0", m); end
        checks++; if (rx_data !== 32'h00000001) begin failures++; $display("FAIL underrun_rx_data got %h exp 00000001", rx_data); end
        frame_end();
        checks++; if (rx_q.size() !== 1) begin failures++; $display("FAIL underrun_rx_count got %0d exp 1", rx_q.size()); end
    endtask

    task automatic test_overrun();
        logic [31:0] m;
        rx_ready = 1'b0;
        ovr_cnt = 0;
        frame_begin();
        spi_word(32'hDEADBEEF, 32, m);
        checks++; if (ovr_cnt !== 0) begin failures++; $display("FAIL overrun_first got %0d exp 0", ovr_cnt); end
        spi_word(32'hCAFEF00D, 32, m);
        frame_end();
        checks++; if (rx_data !== 32'hDEADBEEF) begin failures++; $display("FAIL overrun_rx_data got %h exp deadbeef", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL overrun_rx_valid got %b exp 1", rx_valid); end
        checks++; if (ovr_cnt !== 1) begin failures++; $display("FAIL overrun_count got %0d exp 1", ovr_cnt); end
        rx_ready = 1'b1;
        wait_cyc(2);
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL overrun_drain got %b exp 0", rx_valid); end
    endtask

    task automatic test_frame_err();
        logic [31:0] m;
        push(32'h11111111);
        push(32'h22222222);
        rx_q.delete();
        fe_cnt = 0;
        frame_begin();
        spi_word(32'hFFFFFFFF, 17, m);
        frame_end();
        checks++; if (m !== 32'h00002222) begin failures++; $display("FAIL partial_miso got %h exp 00002222", m); end
        checks++; if (fe_cnt !== 1) begin failures++; $display("FAIL frame_err_count got %0d exp 1", fe_cnt); end
        checks++; if (rx_q.size() !== 0) begin failures++; $display("FAIL partial_rx_count got %0d exp 0", rx_q.size()); end
        frame_begin();
        spi_word(32'h0, 32, m);
        frame_end();
        checks++; if (m !== 32'h22222222) begin failures++; $display("FAIL next_frame_miso got %h exp 22222222", m); end
        checks++; if (fe_cnt !== 1) begin failures++; $display("FAIL next_frame_err got %0d exp 1", fe_cnt); end
    endtask

    task automatic test_fifo_full();
        logic [31:0] w5 [5];
        logic [31:0] m, exp_w;
        w5[0] = 32'h01010101; w5[1] = 32'h02020202; w5[2] = 32'h03030303;
        w5[3] = 32'h04040404; w5[4] = 32'h05050505;
        tx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_data = w5[i];
            checks++;
            if (tx_ready !== (i < 4)) begin failures++; $display("FAIL fifo_ready_%0d got %b exp %b", i, tx_ready, (i < 4)); end
            wait_cyc(1);
        end
        tx_valid = 1'b0;
        frame_begin();
        for (int i = 0; i < 5; i++) begin
            spi_word(32'h0, 32, m);
            exp_w = (i < 4) ? w5[i] : 32'h0;
            checks++; if (m !== exp_w) begin failures++; $display("FAIL fifo_word_%0d got %h exp %h", i, m, exp_w); end
        end
        frame_end();
        rx_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] m;
        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'hAAAA0001 + i);
        frame_begin();
        push(32'hAAAA0005);
        spi_word(32'h13579BDF, 32, m);
        spi_word(32'h2468ACE0, 12, m);
        push(32'hAAAA0006);
        checks++; if ({busy, tx_ready, rx_valid} !== 3'b101) begin failures++; $display("FAIL pre_reset_state got %b exp 101", {busy, tx_ready, rx_valid}); end
        #2;
        presetn = 1'b0;
        #1;
        checks++; if (miso_oe_o !== 1'b0) begin failures++; $display("FAIL midrst_oe got %b exp 0", miso_oe_o); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got %b exp 0", busy); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL midrst_rx_valid got %b exp 0", rx_valid); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL midrst_tx_ready got %b exp 1", tx_ready); end
        sclk_i = 1'b0;
        cs_n_i = 1'b1;
        mosi_i = 1'b0;
        wait_cyc(3);
        presetn = 1'b1;
        wait_cyc(2);
        test_stream("after_reset");
    endtask

    initial begin
        test_reset();
        test_stream("stream");
        test_underrun();
        test_overrun();
        test_frame_err();
        test_fifo_full();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apbspi_spi_slave.md
Name: apbspi_spi_slave

Overview:
Synthesizable SPI slave that forms the far end of the link driven by the apbspi SPI master. It oversamples the master's sclk/cs_n/mosi in the pclk domain and exchanges DATA_WIDTH-bit words MSB-first in mode 0 (CPOL=0, CPHA=0). Transmit words come from a small internal TX FIFO. Receive words are offered on a valid/ready port. It gives the bench and SoC-level tests a real RTL peer in place of a behavioural model.

Parameters:
DATA_WIDTH, 32, bits per SPI word, matching REG_DATA_TX/REG_DATA_RX width
TX_DEPTH, 4, TX FIFO entries; power of two, at least 2
SYNC_STAGES, 2, synchroniser flops on sclk_i, cs_n_i and mosi_i; at least 2

Ports:
pclk  in  1  system clock
presetn  in  1  asynchronous active-low reset
en  in  1  block enable; when low, bus is ignored and miso_oe_o=0
sclk_i  in  1  SPI clock from master, asynchronous to pclk
cs_n_i  in  1  chip select, active low, asynchronous
mosi_i  in  1  master-out data, asynchronous
miso_o  out  1  slave-out data
miso_oe_o  out  1  miso output enable; high only while selected and enabled
tx_data  in  DATA_WIDTH  word pushed into TX FIFO
tx_valid  in  1  push request
tx_ready  out  1  TX FIFO not full
rx_data  out  DATA_WIDTH  last received word
rx_valid  out  1  rx_data holds an unconsumed word
rx_ready  in  1  consumer accepts rx_data
rx_overrun  out  1  one-cycle pulse: a completed word was dropped
tx_underrun  out  1  one-cycle pulse: a word load found the TX FIFO empty
frame_err  out  1  one-cycle pulse: frame ended mid-word
busy  out  1  high in ACTIVE state

Behaviour:
- Reset (presetn low, asynchronous) drives: miso_o=0, miso_oe_o=0, rx_data=0, rx_valid=0, all pulse outputs=0, busy=0. TX FIFO is emptied, so tx_ready=1. Synchroniser flops reset sclk=0 and cs_n=1. Reset mid-frame aborts the frame immediately; there is no recovery phase.
- Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronised sclk and cs_n against one extra delay flop.
- Timing requirement: sclk high and low phases each at least SYNC_STAGES+2 pclk cycles. The first sclk rise must come at least SYNC_STAGES+2 pclk cycles after the cs_n fall.
- State machine has two states, IDLE and ACTIVE.
  - IDLE to ACTIVE on a synchronised cs_n falling edge while en=1. On that cycle, load the shift register from the TX FIFO head and pop it. If the FIFO is empty, load 0 and pulse tx_underrun. Clear the bit counter.
  - ACTIVE to IDLE on a synchronised cs_n rising edge or en falling. If the bit counter is nonzero, discard the partial word and pulse frame_err. No rx_valid is raised for a partial word.
- In ACTIVE:
  - miso_oe_o=1 and miso_o = shift register MSB.
  - Rising sclk: shift mosi into the RX shift register LSB and increment the counter.
  - When the counter reaches DATA_WIDTH, the word is complete and the counter wraps to 0.
  - Falling sclk with counter nonzero: shift TX left by one.
  - Falling sclk with counter 0, after at least one word: load the next TX word from the FIFO (underrun rule as above). Words stream back-to-back inside one frame.
- Latency: miso updates SYNC_STAGES+1 pclk cycles after the physical sclk fall. rx_valid rises SYNC_STAGES+1 cycles after the DATA_WIDTH-th physical sclk rise.
- RX hold register, on word complete:
  - If rx_valid=0, or rx_ready=1 on the same cycle: rx_data takes the new word and rx_valid=1.
  - Otherwise the new word is dropped, rx_data keeps the old word, and rx_overrun pulses.
  - rx_valid clears on rx_valid and rx_ready with no simultaneous completion.
- TX FIFO:
  - A push is accepted on tx_valid and tx_ready.
  - When full, tx_ready=0 and pushes are ignored.
  - A simultaneous push and pop when not full is accepted, with net count unchanged.
  - Pointers wrap modulo TX_DEPTH, with an extra wrap bit for full/empty detection.
- en=0 forces IDLE and miso_oe_o=0. The FIFO and RX register are kept.

Decomposition:
- Shared package apbspi_pkg gets the state typedef (ST_IDLE, ST_ACTIVE) and the default-width constant SPI_WORD_W=32.
- One sub-module, apbspi_sync_edge: SYNC_STAGES synchroniser plus rise/fall detect, instantiated for sclk and cs_n. mosi uses the synchroniser only.
- The TX FIFO stays inline.

Test Plan:
1. Push A5A50F0F and 12345678, then the master sends DEADBEEF and CAFEF00D in one frame. Required: the miso stream is A5A50F0F then 12345678, and rx_valid presents DEADBEEF then CAFEF00D (rx_ready=1).
2. Frame with an empty TX FIFO, master sends 00000001. Required: miso all zeros, tx_underrun pulses exactly once at cs_n fall, and rx_data=00000001.
3. rx_ready held 0, master sends DEADBEEF then CAFEF00D. Required: rx_data stays DEADBEEF, rx_valid=1, and rx_overrun pulses once at the second completion.
4. Push 11111111 and 22222222, then cs_n rises after 17 sclk rises. Required: frame_err pulses and there is no rx_valid. The next frame shifts out 22222222 starting from bit 31.
5. Push 5 words with tx_valid held. Required: tx_ready falls after the 4th push, and the 5th word never appears on miso.
6. presetn asserted mid-word in frame 1. Required: miso_oe_o=0, busy=0, rx_valid=0, tx_ready=1 immediately, with no pclk edge needed. After release, a new frame works with the step 1 values.
